// File: rtl/ysyx_24100006_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
//   arb_state_t : FSM encoding (IDLE -> REQ -> WAIT -> RESP -> IDLE)
//   master_t    : master identifiers, IFU = 0, LSU = 1
//   DEFAULT_TIMEOUT / cnt_width : response timeout default and counter sizing
package ysyx_24100006_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } master_t;

    localparam int DEFAULT_TIMEOUT = 256;

    // Counter only has to reach TIMEOUT-1; keep at least one bit so a
    // disabled or tiny timeout still yields a legal vector.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ysyx_24100006_mem_arbiter_if.sv
// Bus bundle between the arbiter, its two masters (IFU, LSU) and memory.
//
// Handshake rules:
//   Request channels (ifu_req_*, lsu_req_*, mem_req_*) are valid/ready: a
//   transfer happens on a rising clock edge where valid && ready are both 1.
//   The requester holds valid and its payload stable until that edge; ready
//   may depend combinationally on valid. Response channels (*_resp_valid)
//   are single-cycle pulses with no backpressure: the receiver must take
//   the data in the cycle the pulse is high.
//
// Modports:
//   slave  : the arbiter (serves the masters, drives the memory request)
//   master : the environment (drives IFU/LSU requests, models memory)
interface ysyx_24100006_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_resp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [STRB_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp_err;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );

endinterface

// File: rtl/ysyx_24100006_mem_arbiter_rr_pick.sv
// Combinational grant selection between IFU and LSU.
//   ifu_valid, lsu_valid : pending requests
//   last_grant           : master granted most recently
//   grant                : master to serve (meaningful only when any = 1)
//   any                  : at least one request pending
// RR_EN = 0: LSU wins a tie. RR_EN = 1: the tie goes to the master that
// was not granted last.
module ysyx_24100006_rr_pick
    import ysyx_24100006_mem_arbiter_pkg::*;
#(
    parameter int RR_EN = 0
) (
    input  logic    ifu_valid,
    input  logic    lsu_valid,
    input  master_t last_grant,
    output master_t grant,
    output logic    any
);

    always_comb begin
        any   = ifu_valid | lsu_valid;
        grant = MST_IFU;
        if (ifu_valid && lsu_valid) begin
            if ((RR_EN != 0) && (last_grant == MST_LSU)) grant = MST_IFU;
            else                                          grant = MST_LSU;
        end else if (lsu_valid) begin
            grant = MST_LSU;
        end
    end

endmodule

// File: rtl/ysyx_24100006_mem_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and
// load/store (read/write). One transaction is in flight at a time.
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   bus        : IFU/LSU request+response channels and the memory port
//   busy       : high whenever the FSM is not IDLE
//   dbg_state  : current FSM state
// A response that does not arrive within TIMEOUT cycles of acceptance is
// turned into an error response (rdata = 0) so the requester never hangs.
module ysyx_24100006_mem_arbiter
    import ysyx_24100006_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_EN   = 0,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    ysyx_24100006_mem_arbiter_if.slave bus,
    output logic       busy,
    output arb_state_t dbg_state
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    master_t           grant_q, last_grant_q, pick_grant;
    logic              pick_any;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_q;
    logic              timeout_hit;
    logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;
    logic              ifu_err_q, lsu_err_q;

    ysyx_24100006_rr_pick #(.RR_EN(RR_EN)) u_pick (
        .ifu_valid  (bus.ifu_req_valid),
        .lsu_valid  (bus.lsu_req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Response and timeout in the same cycle: the response takes priority,
    // which the datapath below mirrors.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_any)                           state_d = ST_REQ;
            ST_REQ:  if (bus.mem_req_ready)                  state_d = ST_WAIT;
            ST_WAIT: if (bus.mem_resp_valid || timeout_hit)  state_d = ST_RESP;
            ST_RESP:                                         state_d = ST_IDLE;
            default:                                         state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q      <= MST_IFU;
            last_grant_q <= MST_LSU;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            ifu_rdata_q  <= '0;
            ifu_err_q    <= 1'b0;
            lsu_rdata_q  <= '0;
            lsu_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q      <= pick_grant;
                        last_grant_q <= pick_grant;
                    end
                end
                ST_REQ: begin
                    // The payload is not held after acceptance, so remember
                    // whether this was a write to zero its read data later.
                    if (bus.mem_req_ready) begin
                        cnt_q <= '0;
                        wr_q  <= (grant_q == MST_LSU) && bus.lsu_wen;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.mem_resp_valid) begin
                        if (grant_q == MST_IFU) begin
                            ifu_rdata_q <= bus.mem_rdata;
                            ifu_err_q   <= bus.mem_resp_err;
                        end else begin
                            lsu_rdata_q <= wr_q ? '0 : bus.mem_rdata;
                            lsu_err_q   <= bus.mem_resp_err;
                        end
                    end else if (timeout_hit) begin
                        if (grant_q == MST_IFU) begin
                            ifu_rdata_q <= '0;
                            ifu_err_q   <= 1'b1;
                        end else begin
                            lsu_rdata_q <= '0;
                            lsu_err_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory request payload is a pure mux of the granted master; it is
    // zero outside REQ.
    always_comb begin
        bus.mem_req_valid = (state_q == ST_REQ);
        bus.mem_addr      = {ADDR_W{1'b0}};
        bus.mem_wen       = 1'b0;
        bus.mem_wdata     = {DATA_W{1'b0}};
        bus.mem_wmask     = {STRB_W{1'b0}};
        if (state_q == ST_REQ) begin
            if (grant_q == MST_LSU) begin
                bus.mem_addr  = bus.lsu_addr;
                bus.mem_wen   = bus.lsu_wen;
                bus.mem_wdata = bus.lsu_wdata;
                bus.mem_wmask = bus.lsu_wmask;
            end else begin
                bus.mem_addr  = bus.ifu_addr;
            end
        end
    end

    assign bus.ifu_req_ready  = (state_q == ST_REQ)  && (grant_q == MST_IFU) && bus.mem_req_ready;
    assign bus.lsu_req_ready  = (state_q == ST_REQ)  && (grant_q == MST_LSU) && bus.mem_req_ready;
    assign bus.ifu_resp_valid = (state_q == ST_RESP) && (grant_q == MST_IFU);
    assign bus.lsu_resp_valid = (state_q == ST_RESP) && (grant_q == MST_LSU);
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.ifu_resp_err   = ifu_err_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.lsu_resp_err   = lsu_err_q;

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_24100006_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter. Two instances share clock and
// reset: u_dut0 (fixed priority, TIMEOUT=8) with a configurable memory
// model, and u_dut1 (round-robin, TIMEOUT=8) with an always-ready memory.
// Responses are scored against expected words {master, err, rdata}.
module tb_ysyx_24100006_mem_arbiter;
    import ysyx_24100006_mem_arbiter_pkg::*;

    localparam int W = 34;

    logic       clk;
    logic       reset;
    logic       busy0, busy1;
    arb_state_t dbg0, dbg1;

    ysyx_24100006_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    ysyx_24100006_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    ysyx_24100006_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(8)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .busy(busy0), .dbg_state(dbg0)
    );

    ysyx_24100006_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(8)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .busy(busy1), .dbg_state(dbg1)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q_rr[$];
    int          resp_cnt0 = 0;
    int          resp_cnt1 = 0;

    // memory model controls for bus0
    int          stall0      = 0;
    bit          no_resp0    = 0;
    bit          err_inj0    = 0;
    bit          force_resp0 = 0;

    // first-occurrence trackers used by run_bus0
    int          cyc          = 0;
    int          ifu_rdy_cyc  = -1;
    int          lsu_resp_cyc = -1;

    function automatic logic [31:0] data_of(input logic [31:0] addr);
        if (addr == 32'h8000_0000) return 32'h0000_0413;
        return addr ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- memory models ----------------
    logic        acc0, acc0_wen;
    logic [31:0] acc0_addr;
    initial begin
        bus0.mem_req_ready = 1'b0; bus0.mem_resp_valid = 1'b0;
        bus0.mem_rdata = '0; bus0.mem_resp_err = 1'b0;
        acc0 = 1'b0; acc0_wen = 1'b0; acc0_addr = '0;
        forever begin
            @(posedge clk); #1;
            bus0.mem_resp_valid = force_resp0;
            bus0.mem_rdata      = 32'hFFFF_FFFF;
            bus0.mem_resp_err   = 1'b0;
            if (acc0 && !no_resp0) begin
                bus0.mem_resp_valid = 1'b1;
                bus0.mem_rdata      = acc0_wen ? 32'hFFFF_FFFF : data_of(acc0_addr);
                bus0.mem_resp_err   = err_inj0;
            end
            if (bus0.mem_req_valid) begin
                if (stall0 > 0) begin
                    bus0.mem_req_ready = 1'b0;
                    stall0--;
                end else begin
                    bus0.mem_req_ready = 1'b1;
                end
            end else begin
                bus0.mem_req_ready = 1'b0;
            end
            acc0      = bus0.mem_req_valid && bus0.mem_req_ready;
            acc0_addr = bus0.mem_addr;
            acc0_wen  = bus0.mem_wen;
        end
    end

    logic        acc1;
    logic [31:0] acc1_addr;
    initial begin
        bus1.mem_req_ready = 1'b0; bus1.mem_resp_valid = 1'b0;
        bus1.mem_rdata = '0; bus1.mem_resp_err = 1'b0;
        acc1 = 1'b0; acc1_addr = '0;
        forever begin
            @(posedge clk); #1;
            bus1.mem_resp_valid = acc1;
            bus1.mem_rdata      = acc1 ? data_of(acc1_addr) : 32'h0;
            bus1.mem_req_ready  = bus1.mem_req_valid;
            acc1      = bus1.mem_req_valid && bus1.mem_req_ready;
            acc1_addr = bus1.mem_addr;
        end
    end

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (bus0.ifu_resp_valid || bus0.lsu_resp_valid) begin
            resp_cnt0++;
            check("bus0_one_resp_at_a_time", bus0.ifu_resp_valid && bus0.lsu_resp_valid, 0);
            check("bus0_resp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                if (bus0.ifu_resp_valid)
                    check("bus0_ifu_resp", {1'b0, bus0.ifu_resp_err, bus0.ifu_rdata}, exp_q.pop_front());
                else
                    check("bus0_lsu_resp", {1'b1, bus0.lsu_resp_err, bus0.lsu_rdata}, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.ifu_resp_valid || bus1.lsu_resp_valid) begin
            resp_cnt1++;
            check("bus1_resp_expected", exp_q_rr.size() != 0, 1);
            if (exp_q_rr.size() != 0) begin
                if (bus1.ifu_resp_valid)
                    check("bus1_ifu_resp", {1'b0, bus1.ifu_resp_err, bus1.ifu_rdata}, exp_q_rr.pop_front());
                else
                    check("bus1_lsu_resp", {1'b1, bus1.lsu_resp_err, bus1.lsu_rdata}, exp_q_rr.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Runs bus0 until both masters have been accepted and the FSM is idle;
    // each master drops valid right after its accepting edge.
    task automatic run_bus0(input int max_cyc);
        int  n;
        bit  a_i, a_l;
        n = 0;
        while ((bus0.ifu_req_valid || bus0.lsu_req_valid || busy0) && n < max_cyc) begin
            @(negedge clk);
            a_i = bus0.ifu_req_valid && bus0.ifu_req_ready;
            a_l = bus0.lsu_req_valid && bus0.lsu_req_ready;
            if (bus0.ifu_req_ready  && ifu_rdy_cyc  < 0) ifu_rdy_cyc  = cyc;
            if (bus0.lsu_resp_valid && lsu_resp_cyc < 0) lsu_resp_cyc = cyc;
            cyc++;
            @(posedge clk); #1;
            if (a_i) bus0.ifu_req_valid = 1'b0;
            if (a_l) begin
                bus0.lsu_req_valid = 1'b0;
                bus0.lsu_wen       = 1'b0;
            end
            n++;
        end
        check("bus0_drain_in_budget", n < max_cyc, 1);
    endtask

    task automatic lsu_req0(input logic [31:0] addr, input logic wen,
                            input logic [31:0] wdata, input logic [3:0] wmask);
        bus0.lsu_req_valid = 1'b1;
        bus0.lsu_addr      = addr;
        bus0.lsu_wen       = wen;
        bus0.lsu_wdata     = wdata;
        bus0.lsu_wmask     = wmask;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a;
        logic        wen;
        int          sel;
        int          n;
        int          saved;
        int          i_acc, l_acc;
        bit          a_i, a_l;

        reset = 1'b1;
        bus0.ifu_req_valid = 1'b0; bus0.ifu_addr = '0;
        bus0.lsu_req_valid = 1'b0; bus0.lsu_addr = '0; bus0.lsu_wen = 1'b0;
        bus0.lsu_wdata = '0; bus0.lsu_wmask = '0;
        bus1.ifu_req_valid = 1'b0; bus1.ifu_addr = '0;
        bus1.lsu_req_valid = 1'b0; bus1.lsu_addr = '0; bus1.lsu_wen = 1'b0;
        bus1.lsu_wdata = '0; bus1.lsu_wmask = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_state", dbg0, ST_IDLE);
        check("rst_mem_req_valid", bus0.mem_req_valid, 0);
        check("rst_resp_valids", {bus0.ifu_resp_valid, bus0.lsu_resp_valid}, 0);
        check("rst_rdata_err", {bus0.ifu_rdata, bus0.lsu_rdata, bus0.ifu_resp_err, bus0.lsu_resp_err}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {busy0, busy1}, 0);

        // IFU read, cycle-exact latency
        @(posedge clk); #1;
        bus0.ifu_req_valid = 1'b1;
        bus0.ifu_addr      = 32'h8000_0000;
        exp_q.push_back({1'b0, 1'b0, 32'h0000_0413});
        @(negedge clk);
        check("ifu_t0_no_mem_req", bus0.mem_req_valid, 0);
        @(negedge clk);
        check("ifu_t1_mem_req_valid", bus0.mem_req_valid, 1);
        check("ifu_t1_req_ready", bus0.ifu_req_ready, 1);
        check("ifu_t1_lsu_ready", bus0.lsu_req_ready, 0);
        check("ifu_t1_mem_addr", bus0.mem_addr, 32'h8000_0000);
        check("ifu_t1_mem_wpayload", {bus0.mem_wen, bus0.mem_wdata, bus0.mem_wmask}, 0);
        @(posedge clk); #1;
        bus0.ifu_req_valid = 1'b0;
        @(negedge clk);
        check("ifu_t2_ready_low", bus0.ifu_req_ready, 0);
        check("ifu_t2_no_resp", bus0.ifu_resp_valid, 0);
        @(negedge clk);
        check("ifu_t3_resp_valid", bus0.ifu_resp_valid, 1);
        check("ifu_t3_lsu_quiet", {bus0.lsu_resp_valid, bus0.lsu_rdata, bus0.lsu_resp_err}, 0);
        @(negedge clk);
        check("ifu_t4_idle", {busy0, bus0.ifu_resp_valid}, 0);

        // both valid, fixed priority: LSU first, IFU waits for LSU response
        @(posedge clk); #1;
        bus0.ifu_req_valid = 1'b1;
        bus0.ifu_addr      = 32'h8000_0010;
        lsu_req0(32'h8000_2000, 1'b0, 32'h0, 4'h0);
        exp_q.push_back({1'b1, 1'b0, data_of(32'h8000_2000)});
        exp_q.push_back({1'b0, 1'b0, data_of(32'h8000_0010)});
        ifu_rdy_cyc = -1; lsu_resp_cyc = -1;
        run_bus0(60);
        check("prio_lsu_resp_seen", lsu_resp_cyc >= 0, 1);
        check("prio_ifu_ready_after_lsu_resp", ifu_rdy_cyc > lsu_resp_cyc, 1);

        // LSU write: payload passes through, read data forced to 0
        @(posedge clk); #1;
        lsu_req0(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        @(posedge clk);
        @(negedge clk);
        check("wr_mem_wen", bus0.mem_wen, 1);
        check("wr_mem_addr", bus0.mem_addr, 32'h8000_1000);
        check("wr_mem_wdata", bus0.mem_wdata, 32'hDEAD_BEEF);
        check("wr_mem_wmask", bus0.mem_wmask, 4'b0011);
        check("wr_ready", {bus0.lsu_req_ready, bus0.ifu_req_ready}, 2'b10);
        @(posedge clk); #1;
        bus0.lsu_req_valid = 1'b0;
        bus0.lsu_wen       = 1'b0;
        run_bus0(20);
        check("wr_rdata_held_zero", bus0.lsu_rdata, 0);

        // memory stalls acceptance for 5 cycles
        @(posedge clk); #1;
        stall0 = 5;
        bus0.ifu_req_valid = 1'b1;
        bus0.ifu_addr      = 32'h8000_0040;
        exp_q.push_back({1'b0, 1'b0, data_of(32'h8000_0040)});
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_req_valid", bus0.mem_req_valid, 1);
            check("stall_addr_stable", bus0.mem_addr, 32'h8000_0040);
            check("stall_ready_low", bus0.ifu_req_ready, 0);
        end
        @(negedge clk);
        check("stall_accept_pulse", bus0.ifu_req_ready, 1);
        @(posedge clk); #1;
        bus0.ifu_req_valid = 1'b0;
        @(negedge clk);
        check("stall_ready_after_accept", bus0.ifu_req_ready, 0);
        run_bus0(20);

        // memory error response on LSU read
        @(posedge clk); #1;
        err_inj0 = 1'b1;
        lsu_req0(32'h8000_3000, 1'b0, 32'h0, 4'h0);
        exp_q.push_back({1'b1, 1'b1, data_of(32'h8000_3000)});
        run_bus0(20);
        err_inj0 = 1'b0;

        // timeout: memory never answers
        @(posedge clk); #1;
        no_resp0 = 1'b1;
        bus0.ifu_req_valid = 1'b1;
        bus0.ifu_addr      = 32'h8000_0080;
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        @(negedge clk);
        @(negedge clk);
        check("to_accept", bus0.ifu_req_ready, 1);
        @(posedge clk); #1;
        bus0.ifu_req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus0.ifu_resp_valid && n < 20);
        check("to_resp_cycles_from_wait", n, 9);
        @(negedge clk);
        @(negedge clk);
        force_resp0 = 1'b1;
        @(negedge clk);
        force_resp0 = 1'b0;
        check("late_resp_ignored_busy", busy0, 0);
        check("late_resp_ignored_valid", bus0.ifu_resp_valid, 0);
        @(negedge clk);
        check("late_resp_state_idle", dbg0, ST_IDLE);
        check("to_err_held", {bus0.ifu_resp_err, bus0.ifu_rdata}, {1'b1, 32'h0});
        no_resp0 = 1'b0;

        // reset during WAIT aborts silently
        @(posedge clk); #1;
        no_resp0 = 1'b1;
        bus0.ifu_req_valid = 1'b1;
        bus0.ifu_addr      = 32'h8000_00C0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        bus0.ifu_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_in_wait", dbg0, ST_WAIT);
        saved = resp_cnt0;
        reset = 1'b1;
        #1;
        check("rst_mid_async_state", dbg0, ST_IDLE);
        check("rst_mid_busy", busy0, 0);
        check("rst_mid_mem_req", bus0.mem_req_valid, 0);
        check("rst_mid_outputs", {bus0.ifu_rdata, bus0.ifu_resp_err, bus0.lsu_rdata, bus0.lsu_resp_err}, 0);
        @(negedge clk);
        reset = 1'b0;
        no_resp0 = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_mid_no_resp", resp_cnt0, saved);
        check("rst_mid_stays_idle", busy0, 0);

        // randomised traffic on bus0
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            stall0 = $urandom_range(0, 3);
            sel    = $urandom_range(0, 2);
            a      = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
            wen    = 1'($urandom_range(0, 1));
            if (sel != 1) begin
                lsu_req0(a ^ 32'h0000_4000, wen, 32'($urandom), 4'($urandom_range(0, 15)));
                exp_q.push_back({1'b1, 1'b0, wen ? 32'h0 : data_of(a ^ 32'h0000_4000)});
            end
            if (sel != 0) begin
                bus0.ifu_req_valid = 1'b1;
                bus0.ifu_addr      = a;
                exp_q.push_back({1'b0, 1'b0, data_of(a)});
            end
            run_bus0(60);
        end
        check("bus0_queue_drained", exp_q.size(), 0);

        // round-robin on bus1: both held valid for two transactions each
        @(posedge clk); #1;
        bus1.ifu_req_valid = 1'b1;
        bus1.ifu_addr      = 32'h8000_0100;
        bus1.lsu_req_valid = 1'b1;
        bus1.lsu_addr      = 32'h8000_0200;
        for (int k = 0; k < 2; k++) begin
            exp_q_rr.push_back({1'b0, 1'b0, data_of(32'h8000_0100)});
            exp_q_rr.push_back({1'b1, 1'b0, data_of(32'h8000_0200)});
        end
        i_acc = 0; l_acc = 0; n = 0;
        while ((i_acc < 2 || l_acc < 2) && n < 100) begin
            @(negedge clk);
            a_i = bus1.ifu_req_valid && bus1.ifu_req_ready;
            a_l = bus1.lsu_req_valid && bus1.lsu_req_ready;
            if (a_i || a_l)
                check("rr_grant_order", a_l, ((i_acc + l_acc) % 2));
            @(posedge clk); #1;
            if (a_i) begin
                i_acc++;
                if (i_acc == 2) bus1.ifu_req_valid = 1'b0;
            end
            if (a_l) begin
                l_acc++;
                if (l_acc == 2) bus1.lsu_req_valid = 1'b0;
            end
            n++;
        end
        check("rr_accepts_in_budget", n < 100, 1);
        n = 0;
        while (busy1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("rr_responses", resp_cnt1, 4);
        check("rr_queue_drained", exp_q_rr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
